// File: rtl/color_fetch_seq_if.sv
// Colour-fetch bus: badline request, colour RAM read port and pixel-pipeline lookup.
interface color_fetch_seq_if #(
    parameter int AW = 12
) ();
    logic          start;
    logic [AW-1:0] vcbase;
    logic          fetch_en;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          busy;
    logic          done;
    logic [5:0]    char_idx;
    logic [7:0]    char_color;

    modport master (
        output start, vcbase, fetch_en, ram_data, char_idx,
        input  ram_addr, busy, done, char_color
    );

    modport slave (
        input  start, vcbase, fetch_en, ram_data, char_idx,
        output ram_addr, busy, done, char_color
    );
endinterface

// File: rtl/color_fetch_seq.sv
// Colour RAM row fetch engine with line buffer and per-column colour lookup.
// Define COLOR_FETCH_DBUF_EN for front/back line buffers swapped on done.
module color_fetch_seq #(
    parameter int COLS = 40,
    parameter int AW   = 12
) (
    input logic              clk,
    input logic              rst,
    color_fetch_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [5:0] LAST_N = 6'(COLS - 1);
    localparam logic [5:0] NCOLS  = 6'(COLS);

    state_t        state_q, state_d;
    logic [AW-1:0] base_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] issue_addr;
    logic [5:0]    n_q;
    logic          accept;
    logic          issue;
    logic          pv_q;
    logic [5:0]    pidx_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    color_q;
    logic [7:0]    rd_data;

`ifdef COLOR_FETCH_DBUF_EN
    logic [7:0]    linebuf [2][COLS];
    logic          front_q;
`else
    logic [7:0]    linebuf [COLS];
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.fetch_en) begin
                    issue = 1'b1;
                    if (n_q == LAST_N) state_d = DRAIN;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The address goes out combinationally in its issue cycle so the RAM samples it at that edge.
    assign issue_addr     = base_q + AW'(n_q);
    assign bus.ram_addr   = issue ? issue_addr : addr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.char_color = color_q;

    always_comb begin
`ifdef COLOR_FETCH_DBUF_EN
        rd_data = linebuf[front_q][bus.char_idx];
`else
        rd_data = linebuf[bus.char_idx];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            n_q     <= '0;
            pv_q    <= 1'b0;
            pidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            color_q <= '0;
`ifdef COLOR_FETCH_DBUF_EN
            front_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pv_q    <= issue;
            pidx_q  <= n_q;
            done_q  <= (state_q == DRAIN);
            color_q <= (bus.char_idx < NCOLS) ? rd_data : '0;
            if (done_q) busy_q <= 1'b0;
            if (accept) begin
                base_q <= bus.vcbase;
                n_q    <= '0;
                busy_q <= 1'b1;
            end
            if (issue) begin
                addr_q <= issue_addr;
                n_q    <= n_q + 6'd1;
            end
`ifdef COLOR_FETCH_DBUF_EN
            // Swap on the same edge as the final capture and the rise of done.
            if (state_q == DRAIN) front_q <= ~front_q;
`endif
        end
    end

    // Storage has no reset; captures follow the pipeline valid bit only.
    always_ff @(posedge clk) begin
        if (pv_q) begin
`ifdef COLOR_FETCH_DBUF_EN
            linebuf[~front_q][pidx_q] <= bus.ram_data;
`else
            linebuf[pidx_q] <= bus.ram_data;
`endif
        end
    end
endmodule
